// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types, constants and helpers for the load/store unit.
//   lsu_state_t : FSM states of the unit (IDLE, XFER, RESP)
//   SZ_*        : legal access sizes in bytes
//   size_legal  : true when a size is 1, 2, 4 or 8 bytes
//   extend      : zero- or sign-extends the low 'size' bytes of a value
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } lsu_state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    function automatic logic size_legal(input logic [3:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) || (size == SZ_D);
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] data,
                                           input logic [3:0]  size,
                                           input logic        sign_ext);
        logic [63:0] result;
        case (size)
            SZ_B:    result = sign_ext ? {{56{data[7]}},  data[7:0]}  : {56'd0, data[7:0]};
            SZ_H:    result = sign_ext ? {{48{data[15]}}, data[15:0]} : {48'd0, data[15:0]};
            SZ_W:    result = sign_ext ? {{32{data[31]}}, data[31:0]} : {32'd0, data[31:0]};
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_chunk_sel.sv
// ---------------------------------------------------------------------------
// lsu_chunk_sel
// Picks the size of the next datamem transfer: the largest power of two that
// does not exceed the bytes remaining, does not exceed 8, and keeps the
// transfer naturally aligned at the current address.
//   addr_lo : low three bits of the current byte address
//   rem     : bytes still to transfer (never 0 while in use)
//   chunk   : transfer size in bytes (1, 2, 4 or 8)
// ---------------------------------------------------------------------------
module lsu_chunk_sel
    import lsu_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  logic [63:0] rem,
    output logic [3:0]  chunk
);

    logic [3:0] align_lim;
    logic [3:0] rem_lim;

    // NOTE: every signal written in a combinational block gets a value on
    // every path (here via if/else chains ending in else); a missed path
    // infers a latch.
    always_comb begin
        if (addr_lo[0])      align_lim = SZ_B;
        else if (addr_lo[1]) align_lim = SZ_H;
        else if (addr_lo[2]) align_lim = SZ_W;
        else                 align_lim = SZ_D;

        if (rem >= 64'd8)      rem_lim = SZ_D;
        else if (rem >= 64'd4) rem_lim = SZ_W;
        else if (rem >= 64'd2) rem_lim = SZ_H;
        else                   rem_lim = SZ_B;

        // Both limits are powers of two, so the smaller one satisfies both.
        chunk = (align_lim < rem_lim) ? align_lim : rem_lim;
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory port between the MEM stage and datamem.
// Accepts 1/2/4/8-byte loads and stores at any byte address, splits them into
// naturally aligned datamem transfers, assembles and extends load data, and
// rejects out-of-range or badly sized requests with resp_err.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req_*               : request handshake (valid/ready) and fields
//   resp_valid/err/rdata: one-cycle completion pulse with status and data
//   mem_*               : datamem initiator port; mem_read_data is
//                         combinational and valid in the issuing cycle
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);

    lsu_state_t  state;
    logic        write_q;
    logic        signed_q;
    logic        err_q;
    logic [3:0]  size_q;
    logic [63:0] wdata_q;
    logic [63:0] cur_addr;
    logic [63:0] rem;
    logic [2:0]  off_q;      // cur_addr - base; an access never spans more than 8 bytes
    logic [63:0] acc;

    logic [3:0]  chunk;
    logic [64:0] end_addr;
    logic        req_legal;
    logic [63:0] rd_shift;
    logic [63:0] acc_next;
    logic        in_xfer;

    lsu_chunk_sel u_chunk_sel (
        .addr_lo (cur_addr[2:0]),
        .rem     (rem),
        .chunk   (chunk)
    );

    // 65-bit sum so a request near the top of the 64-bit space cannot wrap
    // around and pass the range check.
    assign end_addr  = {1'b0, req_addr} + {61'd0, req_size};
    assign req_legal = size_legal(req_size) && (end_addr <= 65'(DATA_MEM_SIZE));

    // Move the returned chunk up to its byte offset within the access and
    // merge only the bytes this chunk covers.
    assign rd_shift = mem_read_data << {off_q, 3'b000};

    always_comb begin
        acc_next = acc;
        for (int j = 0; j < 8; j++) begin
            if ((4'(j) >= {1'b0, off_q}) && (4'(j) < ({1'b0, off_q} + chunk)))
                acc_next[8*j +: 8] = rd_shift[8*j +: 8];
        end
    end

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 4'd0;
            wdata_q  <= 64'd0;
            cur_addr <= 64'd0;
            rem      <= 64'd0;
            off_q    <= 3'd0;
            acc      <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        wdata_q  <= req_wdata;
                        cur_addr <= req_addr;
                        rem      <= {60'd0, req_size};
                        off_q    <= 3'd0;
                        acc      <= 64'd0;
                        err_q    <= !req_legal;
                        state    <= req_legal ? XFER : RESP;
                    end
                end
                XFER: begin
                    cur_addr <= cur_addr + {60'd0, chunk};
                    rem      <= rem - {60'd0, chunk};
                    // An 8-byte chunk only occurs as the single chunk at
                    // offset 0, so the 3-bit wrap here is never observed.
                    off_q    <= off_q + chunk[2:0];
                    if (!write_q)
                        acc <= acc_next;
                    if (rem == {60'd0, chunk})
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Enables decode straight from the state register so an asynchronous
    // reset removes them in the same cycle.
    assign in_xfer          = (state == XFER);
    assign req_ready        = (state == IDLE);
    assign resp_valid       = (state == RESP);
    assign resp_err         = resp_valid && err_q;
    assign resp_rdata       = (resp_valid && !err_q && !write_q) ? extend(acc, size_q, signed_q) : 64'd0;

    assign mem_address      = in_xfer ? cur_addr : 64'd0;
    assign mem_xfer_size    = in_xfer ? chunk : 4'd0;
    assign mem_write_enable = in_xfer && write_q;
    assign mem_read_enable  = in_xfer && !write_q;
    assign mem_write_data   = mem_write_enable ? (wdata_q >> {off_q, 3'b000}) : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit with a byte-array datamem model,
// a transfer log and a response scoreboard.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [3:0]  req_size = 4'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_address;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [63:0] mem_write_data;
    logic [3:0]  mem_xfer_size;
    logic [63:0] mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int en_count = 0;
    int last_resp_cyc = 0;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          lat;
        int          acc_cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  size;
        logic [63:0] wdata;
    } chunk_t;
    chunk_t chunk_log[$];

    logic [7:0] dmem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    load_store_unit #(.DATA_MEM_SIZE(1024)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_err         (resp_err),
        .resp_rdata       (resp_rdata),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_xfer_size    (mem_xfer_size),
        .mem_read_data    (mem_read_data)
    );

    // Datamem model: byte lane i of the bus maps to address + i.
    always @(posedge clk) begin
        if (mem_write_enable)
            for (int i = 0; i < 8; i++)
                if (i < int'(mem_xfer_size))
                    dmem[mem_address[9:0] + 10'(i)] <= mem_write_data[8*i +: 8];
    end

    always @* begin
        mem_read_data = 64'd0;
        if (mem_read_enable)
            for (int i = 0; i < 8; i++)
                if (i < int'(mem_xfer_size))
                    mem_read_data[8*i +: 8] = dmem[mem_address[9:0] + 10'(i)];
    end

    // Log every issued transfer, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_write_enable || mem_read_enable) begin
            chunk_log.push_back('{addr: mem_address, size: mem_xfer_size, wdata: mem_write_data});
            en_count <= en_count + 1;
        end
    end

    function automatic logic [63:0] size_mask(input logic [3:0] size);
        logic [63:0] one = 64'd1;
        return (size >= 4'd8) ? {64{1'b1}} : ((one << (8 * size)) - 64'd1);
    endfunction

    // Presents a request from a negedge and holds it until accepted; the
    // expected response is queued at the acceptance cycle.
    task automatic send_req(input logic w, input logic s, input logic [63:0] a,
                            input logic [3:0] sz, input logic [63:0] wd,
                            input logic e, input logic [63:0] rd, input int lat);
        req_write  = w;
        req_signed = s;
        req_addr   = a;
        req_size   = sz;
        req_wdata  = wd;
        req_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                sb.push_back('{err: e, rdata: rd, lat: lat, acc_cyc: cyc});
                @(posedge clk);
                @(negedge clk);
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout addr=%h: req_ready never seen, required 1", a);
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for the next response and compares it with the oldest
    // scoreboard entry, then checks that resp_valid was a single-cycle pulse.
    task automatic expect_resp(input string name);
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin
                last_resp_cyc = cyc;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_unexpected: resp_valid with empty scoreboard", name);
                    return;
                end
                e = sb.pop_front();
                n_tests++;
                if (resp_err !== e.err) begin
                    n_fail++;
                    $display("FAIL %s_err: got %b, required %b", name, resp_err, e.err);
                end
                n_tests++;
                if (resp_rdata !== e.rdata) begin
                    n_fail++;
                    $display("FAIL %s_rdata: got %h, required %h", name, resp_rdata, e.rdata);
                end
                n_tests++;
                if (cyc - e.acc_cyc != e.lat) begin
                    n_fail++;
                    $display("FAIL %s_latency: got %0d, required %0d", name, cyc - e.acc_cyc, e.lat);
                end
                @(negedge clk);
                n_tests++;
                if (resp_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_pulse: resp_valid got %b, required 0", name, resp_valid);
                end
                return;
            end
            @(negedge clk);
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s_timeout: resp_valid never seen, required 1", name);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if ({req_ready, resp_valid, resp_err, mem_write_enable, mem_read_enable} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 10000",
                     {req_ready, resp_valid, resp_err, mem_write_enable, mem_read_enable});
        end
        n_tests++;
        if ({resp_rdata, mem_address, mem_write_data, mem_xfer_size} !== 196'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h, required all 0",
                     resp_rdata, mem_address, mem_write_data, mem_xfer_size);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_aligned();
        int c0;
        c0 = chunk_log.size();
        send_req(1'b1, 1'b0, 64'h10, 4'd8, 64'h1122334455667788, 1'b0, 64'd0, 2);
        expect_resp("st8_aligned");
        n_tests++;
        if (chunk_log.size() - c0 != 1) begin
            n_fail++;
            $display("FAIL st8_chunks: got %0d, required 1", chunk_log.size() - c0);
        end
        c0 = chunk_log.size();
        send_req(1'b0, 1'b0, 64'h10, 4'd8, 64'd0, 1'b0, 64'h1122334455667788, 2);
        expect_resp("ld8_aligned");
        n_tests++;
        if (chunk_log.size() - c0 != 1) begin
            n_fail++;
            $display("FAIL ld8_chunks: got %0d, required 1", chunk_log.size() - c0);
        end
    endtask

    task automatic test_unaligned();
        int c0;
        logic [63:0] exp_addr [4] = '{64'd3, 64'd4, 64'd8, 64'd10};
        logic [3:0]  exp_size [4] = '{4'd1, 4'd4, 4'd2, 4'd1};
        logic [63:0] exp_data [4] = '{64'h01, 64'h05040302, 64'h0706, 64'h08};
        chunk_t ch;
        c0 = chunk_log.size();
        send_req(1'b1, 1'b0, 64'd3, 4'd8, 64'h0807060504030201, 1'b0, 64'd0, 5);
        expect_resp("st8_unaligned");
        n_tests++;
        if (chunk_log.size() - c0 != 4) begin
            n_fail++;
            $display("FAIL st8u_chunks: got %0d, required 4", chunk_log.size() - c0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                ch = chunk_log[c0 + k];
                n_tests++;
                if (ch.addr !== exp_addr[k] || ch.size !== exp_size[k] ||
                    (ch.wdata & size_mask(ch.size)) !== exp_data[k]) begin
                    n_fail++;
                    $display("FAIL st8u_chunk%0d: got %0d@%h data %h, required %0d@%h data %h",
                             k, ch.size, ch.addr, ch.wdata & size_mask(ch.size),
                             exp_size[k], exp_addr[k], exp_data[k]);
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (dmem[3 + k] !== 8'(k + 1)) begin
                n_fail++;
                $display("FAIL st8u_byte%0d: got %h, required %h", 3 + k, dmem[3 + k], 8'(k + 1));
            end
        end
        send_req(1'b0, 1'b0, 64'd3, 4'd8, 64'd0, 1'b0, 64'h0807060504030201, 5);
        expect_resp("ld8_unaligned");
    endtask

    task automatic test_sign_ext();
        send_req(1'b1, 1'b0, 64'h20, 4'd1, 64'h80, 1'b0, 64'd0, 2);
        expect_resp("stb");
        send_req(1'b0, 1'b1, 64'h20, 4'd1, 64'd0, 1'b0, 64'hFFFFFFFFFFFFFF80, 2);
        expect_resp("ldb_signed");
        send_req(1'b0, 1'b0, 64'h20, 4'd1, 64'd0, 1'b0, 64'h80, 2);
        expect_resp("ldb_unsigned");
        send_req(1'b1, 1'b0, 64'h25, 4'd2, 64'h8001, 1'b0, 64'd0, 3);
        expect_resp("sth_split");
        send_req(1'b0, 1'b1, 64'h25, 4'd2, 64'd0, 1'b0, 64'hFFFFFFFFFFFF8001, 3);
        expect_resp("ldh_signed");
        send_req(1'b0, 1'b0, 64'h25, 4'd2, 64'd0, 1'b0, 64'h8001, 3);
        expect_resp("ldh_unsigned");
    endtask

    task automatic test_illegal();
        int en0;
        en0 = en_count;
        send_req(1'b0, 1'b0, 64'd1022, 4'd4, 64'd0, 1'b1, 64'd0, 1);
        expect_resp("err_range");
        send_req(1'b1, 1'b0, 64'd0, 4'd3, 64'hDEAD, 1'b1, 64'd0, 1);
        expect_resp("err_size");
        send_req(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 4'd8, 64'd0, 1'b1, 64'd0, 1);
        expect_resp("err_wrap");
        n_tests++;
        if (en_count != en0) begin
            n_fail++;
            $display("FAIL err_enables: got %0d enabled cycles, required 0", en_count - en0);
        end
    endtask

    task automatic test_back_to_back();
        int r0, r1, r2;
        fork
            begin
                send_req(1'b0, 1'b0, 64'h10, 4'd8, 64'd0, 1'b0, 64'h1122334455667788, 2);
                send_req(1'b0, 1'b0, 64'h20, 4'd1, 64'd0, 1'b0, 64'h80, 2);
                send_req(1'b0, 1'b1, 64'h14, 4'd4, 64'd0, 1'b0, 64'h11223344, 2);
            end
            begin
                expect_resp("b2b_0");
                r0 = last_resp_cyc;
                expect_resp("b2b_1");
                r1 = last_resp_cyc;
                expect_resp("b2b_2");
                r2 = last_resp_cyc;
            end
        join
        n_tests++;
        if (r1 - r0 != 3 || r2 - r1 != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d and %0d, required 3 and 3", r1 - r0, r2 - r1);
        end
    endtask

    task automatic test_reset_mid_xfer();
        logic saw_resp = 1'b0;
        req_write  = 1'b1;
        req_signed = 1'b0;
        req_addr   = 64'd3;
        req_size   = 4'd8;
        req_wdata  = 64'h1817161514131211;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_write_enable !== 1'b1 || mem_address !== 64'd4) begin
            n_fail++;
            $display("FAIL rst_chunk2: got we=%b addr=%h, required we=1 addr=4", mem_write_enable, mem_address);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (mem_write_enable !== 1'b0 || mem_read_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_enables: got we=%b re=%b, required 0 0", mem_write_enable, mem_read_enable);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        n_tests++;
        if (saw_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_resp: resp_valid got 1, required 0");
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_ready: got %b, required 1", req_ready);
        end
        n_tests++;
        if (dmem[3] !== 8'h11 || dmem[4] !== 8'h02) begin
            n_fail++;
            $display("FAIL rst_partial: got @3=%h @4=%h, required @3=11 @4=02", dmem[3], dmem[4]);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_sign_ext();
        test_illegal();
        test_back_to_back();
        test_reset_mid_xfer();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
